// File: rtl/axi_slave_mem.sv
// Memory-backed AXI-style slave: a 2^ADDR_W x 8 byte array served by independent
// read and write engines that share one clock and run concurrently.
module axi_slave_mem #(
    parameter int ADDR_W     = 8,
    parameter int RD_WAIT    = 1,
    parameter int MAX_WBEATS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ARVALID,
    input  logic [15:0] ARPACK,
    output logic        ARREADY,
    input  logic        RREADY,
    output logic        RVALID,
    output logic        RLAST,
    output logic [8:0]  RPACK,
    input  logic        AWVALID,
    input  logic [11:0] AWPACK,
    output logic        AWREADY,
    input  logic        WVALID,
    input  logic [7:0]  WDATA,
    input  logic        WLAST,
    output logic        WREADY,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [4:0]  BRESP,
    output logic [1:0]  dbg_rd_state_o,
    output logic [1:0]  dbg_wr_state_o,
    output logic [3:0]  dbg_rd_id_o
);

    // Handshake: a beat moves on every rising edge where VALID and READY are both 1;
    // a raised VALID keeps its payload stable until that edge.
    localparam int CNT_W = $clog2(MAX_WBEATS + 1);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

    logic [7:0] mem [2**ADDR_W];

    rd_state_t         r_state_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [ADDR_W-1:0] r_addr_d;
    logic [3:0]        r_len_q;
    logic [3:0]        r_cnt_q;
    logic [3:0]        r_id_q;
    logic [3:0]        r_wait_q;
    logic              r_err_q;
    logic              r_err_d;

    wr_state_t         w_state_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [3:0]        w_id_q;
    logic [CNT_W-1:0]  w_cnt_q;
    logic              w_err_q;
    logic              w_err_d;
    logic              w_over;
    logic              w_wrap;
    logic              mem_we;

    assign dbg_rd_state_o = r_state_q;
    assign dbg_wr_state_o = w_state_q;
    assign dbg_rd_id_o    = r_id_q;

    // Stepping past the top address inside a burst flags every later beat as an error.
    assign r_addr_d = r_addr_q + 1'b1;
    assign r_err_d  = r_err_q | (r_addr_q == '1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_id_q    <= '0;
            r_wait_q  <= '0;
            r_err_q   <= 1'b0;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RLAST     <= 1'b0;
            RPACK     <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ARVALID) begin
                        r_addr_q  <= ARPACK[15:8];
                        r_len_q   <= ARPACK[7:4];
                        r_id_q    <= ARPACK[3:0];
                        r_cnt_q   <= '0;
                        r_err_q   <= 1'b0;
                        ARREADY   <= 1'b1;
                        r_state_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    ARREADY  <= 1'b0;
                    r_wait_q <= '0;
                    if (RD_WAIT == 0) begin
                        RVALID    <= 1'b1;
                        RPACK     <= {mem[r_addr_q], r_err_q};
                        RLAST     <= (r_len_q == 4'd0);
                        r_state_q <= R_DATA;
                    end else begin
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_wait_q == 4'(RD_WAIT - 1)) begin
                        RVALID    <= 1'b1;
                        RPACK     <= {mem[r_addr_q], r_err_q};
                        RLAST     <= (r_len_q == 4'd0);
                        r_state_q <= R_DATA;
                    end else begin
                        r_wait_q <= r_wait_q + 4'd1;
                    end
                end
                R_DATA: begin
                    // The next beat is fetched at the transfer edge, so a same-cycle write
                    // to the presented address cannot alter the beat already on RPACK.
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID    <= 1'b0;
                            RLAST     <= 1'b0;
                            RPACK     <= '0;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_addr_q <= r_addr_d;
                            r_cnt_q  <= r_cnt_q + 4'd1;
                            r_err_q  <= r_err_d;
                            RPACK    <= {mem[r_addr_d], r_err_d};
                            RLAST    <= ((r_cnt_q + 4'd1) == r_len_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // The beat counter saturates at MAX_WBEATS, so every beat past it stays an overrun.
    assign w_over  = (w_cnt_q == CNT_W'(MAX_WBEATS));
    assign w_wrap  = (w_cnt_q != '0) && (w_addr_q == '0);
    assign w_err_d = w_err_q | w_wrap | w_over;
    assign mem_we  = rst && (w_state_q == W_DATA) && WVALID && !w_over;

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_id_q    <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (AWVALID) begin
                        w_addr_q  <= AWPACK[11:4];
                        w_id_q    <= AWPACK[3:0];
                        w_cnt_q   <= '0;
                        w_err_q   <= 1'b0;
                        AWREADY   <= 1'b1;
                        w_state_q <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    AWREADY   <= 1'b0;
                    WREADY    <= 1'b1;
                    w_state_q <= W_DATA;
                end
                W_DATA: begin
                    if (WVALID) begin
                        w_addr_q <= w_addr_q + 1'b1;
                        w_err_q  <= w_err_d;
                        if (!w_over) begin
                            w_cnt_q <= w_cnt_q + 1'b1;
                        end
                        if (WLAST) begin
                            WREADY    <= 1'b0;
                            BVALID    <= 1'b1;
                            BRESP     <= {w_id_q, w_err_d};
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID    <= 1'b0;
                        BRESP     <= '0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[w_addr_q] <= WDATA;
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: reset, bursts, address wrap, overrun,
// read-before-write ordering and mid-burst reset, all against hand-computed values.
module tb_axi_slave_mem;

    localparam int RD_WAIT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ARVALID;
    logic [15:0] ARPACK;
    logic        ARREADY;
    logic        RREADY;
    logic        RVALID;
    logic        RLAST;
    logic [8:0]  RPACK;
    logic        AWVALID;
    logic [11:0] AWPACK;
    logic        AWREADY;
    logic        WVALID;
    logic [7:0]  WDATA;
    logic        WLAST;
    logic        WREADY;
    logic        BVALID;
    logic        BREADY;
    logic [4:0]  BRESP;
    logic [1:0]  dbg_rd_state;
    logic [1:0]  dbg_wr_state;
    logic [3:0]  dbg_rd_id;

    int n_checks = 0;
    int n_fail   = 0;

    axi_slave_mem #(.ADDR_W(8), .RD_WAIT(RD_WAIT), .MAX_WBEATS(16)) dut (
        .clk(clk), .rst(rst),
        .ARVALID(ARVALID), .ARPACK(ARPACK), .ARREADY(ARREADY),
        .RREADY(RREADY), .RVALID(RVALID), .RLAST(RLAST), .RPACK(RPACK),
        .AWVALID(AWVALID), .AWPACK(AWPACK), .AWREADY(AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .dbg_rd_state_o(dbg_rd_state), .dbg_wr_state_o(dbg_wr_state),
        .dbg_rd_id_o(dbg_rd_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Burst of n beats with data d0, d0+1, ...; BREADY held low for bhold cycles.
    task automatic write_burst(input logic [7:0] addr, input logic [3:0] id, input int n,
                               input logic [7:0] d0, input logic [4:0] bresp,
                               input int bhold, input string tag);
        AWVALID = 1'b1;
        AWPACK  = {addr, id};
        tick();
        check({tag, "_awready"}, AWREADY, 1);
        AWVALID = 1'b0;
        tick();
        check({tag, "_wready"}, WREADY, 1);
        for (int i = 0; i < n; i++) begin
            WVALID = 1'b1;
            WDATA  = d0 + 8'(i);
            WLAST  = (i == n - 1);
            tick();
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        check({tag, "_wready_off"}, WREADY, 0);
        check({tag, "_bvalid_bresp"}, {BVALID, BRESP}, {1'b1, bresp});
        for (int i = 0; i < bhold; i++) begin
            tick();
            check({tag, "_bhold"}, {BVALID, BRESP}, {1'b1, bresp});
        end
        BREADY = 1'b1;
        tick();
        check({tag, "_bvalid_drop"}, BVALID, 0);
        BREADY = 1'b0;
    endtask

    // Burst of len+1 beats expected to carry d0, d0+1, ... with RRESP=OKAY.
    task automatic read_check(input logic [7:0] addr, input logic [3:0] len,
                              input logic [7:0] d0, input string tag);
        int lat;
        ARVALID = 1'b1;
        ARPACK  = {addr, len, 4'h1};
        RREADY  = 1'b1;
        tick();
        check({tag, "_arready"}, ARREADY, 1);
        ARVALID = 1'b0;
        lat = 0;
        while (!RVALID && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, RD_WAIT + 1);
        for (int b = 0; b <= int'(len); b++) begin
            check({tag, "_rpack"}, RPACK, {d0 + 8'(b), 1'b0});
            check({tag, "_rlast"}, RLAST, (b == int'(len)));
            tick();
        end
        check({tag, "_end"}, {RVALID, ARREADY}, 2'b00);
        RREADY = 1'b0;
    endtask

    initial begin
        logic [8:0] exp4 [4];
        int  beat;
        int  cyc;
        bit  ph;

        rst = 1'b0; ARVALID = 1'b1; ARPACK = '0; RREADY = 1'b0;
        AWVALID = 1'b1; AWPACK = '0; WVALID = 1'b0; WDATA = '0; WLAST = 1'b0; BREADY = 1'b0;

        // Reset holds every output low even with both address channels requesting.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", {ARREADY, RVALID, RLAST, RPACK, AWREADY, WREADY, BVALID, BRESP}, 0);
        end
        rst = 1'b1;
        tick();
        check("post_reset_pulses", {ARREADY, AWREADY}, 2'b11);
        ARVALID = 1'b0;
        AWVALID = 1'b0;
        tick();
        check("pulse_one_cycle", {ARREADY, AWREADY}, 2'b00);
        rst = 1'b0;
        tick();
        check("reset_abandon", {RVALID, WREADY, BVALID}, 3'b000);
        rst = 1'b1;
        tick();

        // Three-beat write, response held under back-pressure, then read back.
        write_burst(8'h10, 4'h3, 3, 8'hA1, 5'b00110, 4, "t2");
        read_check(8'h10, 4'd2, 8'hA1, "t3");

        // Wrap across the top of memory on both write and read, with RREADY toggling.
        write_burst(8'hFE, 4'h5, 4, 8'hB0, 5'b01011, 0, "t4w");
        exp4 = '{9'h160, 9'h162, 9'h165, 9'h167};
        ARVALID = 1'b1;
        ARPACK  = {8'hFE, 4'h3, 4'h2};
        RREADY  = 1'b0;
        tick();
        check("t4_arready", ARREADY, 1);
        ARVALID = 1'b0;
        ph = 1'b1;
        beat = 0;
        cyc = 0;
        while (beat < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (RVALID) begin
                check("t4_rpack", RPACK, exp4[beat]);
                check("t4_rlast", RLAST, (beat == 3));
                RREADY = ph;
                ph = !ph;
                if (RREADY) beat++;
            end else begin
                RREADY = 1'b0;
            end
        end
        check("t4_beats", beat, 4);
        tick();
        check("t4_rvalid_drop", RVALID, 0);
        RREADY = 1'b0;

        // Overrun: beat 17 lands on 0x50 but must not overwrite its 0x77.
        write_burst(8'h50, 4'h2, 1, 8'h77, 5'b00100, 0, "t5pre");
        write_burst(8'h40, 4'h7, 17, 8'hC0, 5'b01111, 0, "t5w");
        read_check(8'h40, 4'd15, 8'hC0, "t5r");
        read_check(8'h50, 4'd0, 8'h77, "t5keep");

        // A write in the same cycle as the read beat at 0x20 leaves that beat with old data.
        write_burst(8'h20, 4'h4, 1, 8'h11, 5'b01000, 0, "t6pre");
        ARVALID = 1'b1;
        ARPACK  = {8'h20, 4'h0, 4'h1};
        tick();
        check("t6_arready", ARREADY, 1);
        ARVALID = 1'b0;
        cyc = 0;
        while (!RVALID && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t6_rpack_old", {RVALID, RPACK}, {1'b1, 9'h022});
        AWVALID = 1'b1;
        AWPACK  = {8'h20, 4'h4};
        tick();
        check("t6_awready", AWREADY, 1);
        AWVALID = 1'b0;
        tick();
        check("t6_wready", WREADY, 1);
        check("t6_rpack_hold", {RVALID, RPACK}, {1'b1, 9'h022});
        WVALID = 1'b1; WDATA = 8'h99; WLAST = 1'b1; RREADY = 1'b1;
        tick();
        WVALID = 1'b0; WLAST = 1'b0; RREADY = 1'b0;
        check("t6_read_done", RVALID, 0);
        check("t6_bresp", {BVALID, BRESP}, {1'b1, 5'b01000});
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        read_check(8'h20, 4'd0, 8'h99, "t6new");

        // Concurrent read and write bursts, then reset in the middle of both.
        ARVALID = 1'b1; ARPACK = {8'h40, 4'hF, 4'h0};
        AWVALID = 1'b1; AWPACK = {8'h60, 4'h2};
        RREADY  = 1'b1;
        tick();
        check("t7_both_accepted", {ARREADY, AWREADY}, 2'b11);
        ARVALID = 1'b0;
        AWVALID = 1'b0;
        tick();
        tick();
        WVALID = 1'b1; WDATA = 8'h55; WLAST = 1'b0;
        tick();
        check("t7_midburst", {RVALID, WREADY}, 2'b11);
        rst = 1'b0;
        tick();
        check("t7_reset", {RVALID, WREADY, BVALID, ARREADY, AWREADY}, 5'b00000);
        rst = 1'b1; WVALID = 1'b0; RREADY = 1'b0;
        tick();
        tick();
        check("t7_no_partial", {RVALID, BVALID}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
